// File: rtl/data_mem.sv
// data_mem: single-outstanding load/store responder in front of a DEPTH_WORDS x 32
// synchronous RAM. A request is accepted in IDLE. The RAM is written or read on that
// same edge. The response is presented LATENCY cycles later and held until rsp_ready.
module data_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_width,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [1:0]  cnt, cnt_next;
  logic [1:0]  sync;
  logic        accept;

  // Request decode.
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [AW-1:0] idx;
  logic        mem_we;
  logic        mem_re;

  // Fields captured at accept. Everything the response needs is stored here.
  logic        lat_write;
  logic [1:0]  lat_width;
  logic        lat_unsigned;
  logic [1:0]  lat_off;
  logic        lat_err;

  // Storage and response formatting.
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata;
  logic [31:0] shifted;
  logic [31:0] load_val;

  // Two-flop reset-release synchroniser. Requests are gated until it fills.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], 1'b1};
    end
  end

  // While reset is held, req_ready reads 1. After release it stays low until the
  // synchroniser has filled, so that ready never advertises an accept that cannot happen.
  assign req_ready = (state == IDLE) && (sync[1] || !rst_n);
  assign accept    = req_valid && (state == IDLE) && sync[1];

  // Classify alignment per access width.
  always_comb begin
    misaligned = 1'b0;
    case (req_width)
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Compare the full word index so that high addresses fault instead of wrapping.
  assign out_of_range = (req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign req_err      = misaligned || out_of_range || (req_width == 2'b11);

  // Build byte enables. Replicate the right-aligned store data onto every lane.
  always_comb begin
    be    = 4'b0000;
    wlane = req_wdata;
    case (req_width)
      2'b00: begin
        be    = 4'b0001 << req_addr[1:0];
        wlane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be    = req_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wlane = req_wdata;
      end
      default: begin
        be    = 4'b0000;
        wlane = req_wdata;
      end
    endcase
  end

  assign idx    = req_addr[AW+1:2];
  assign mem_we = accept && req_write && !req_err;
  assign mem_re = accept && !req_write && !req_err;

  // RAM port: byte-enabled write and registered read, both on the accept edge, never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][b*8 +: 8] <= wlane[b*8 +: 8];
        end
      end
    end
    if (mem_re) begin
      rdata <= mem[idx];
    end
  end

  // Capture the request attributes that shape the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_write    <= 1'b0;
      lat_width    <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_off      <= 2'b00;
      lat_err      <= 1'b0;
    end else if (accept) begin
      lat_write    <= req_write;
      lat_width    <= req_width;
      lat_unsigned <= req_unsigned;
      lat_off      <= req_addr[1:0];
      lat_err      <= req_err;
    end
  end

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. WAIT counts LATENCY-1 down to zero. RESP holds until retired.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_next   = 2'(LATENCY - 1);
          state_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - 2'd1;
        if (cnt <= 2'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 2'd0;
      end
    endcase
  end

  // Align the loaded word to the access offset, then mask and extend it.
  always_comb begin
    shifted  = rdata >> {lat_off, 3'b000};
    load_val = shifted;
    case (lat_width)
      2'b00: load_val = lat_unsigned ? {24'd0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: load_val = lat_unsigned ? {16'd0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Outputs come from registers only, so they stay stable for as long as RESP lasts.
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid && lat_err;
  assign rsp_rdata = (rsp_valid && !lat_write && !lat_err) ? load_val : 32'd0;

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: two data_mem instances (LATENCY 1 and 3) checked every cycle against
// a byte-array model with an expected-response queue, plus literal checks on known cases.
module tb_data_mem;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n[2], req_valid[2], req_ready[2], req_write[2], req_unsigned[2];
  logic        rsp_valid[2], rsp_ready[2], rsp_err[2];
  logic [1:0]  req_width[2];
  logic [31:0] req_addr[2], req_wdata[2], rsp_rdata[2];

  data_mem #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_width(req_width[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  data_mem #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_width(req_width[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  typedef struct {
    logic [31:0] data;
    logic        err;
    longint      acc;
  } exp_t;

  int          vectors = 0;
  int          miscompares = 0;
  longint      cyc = 0;
  exp_t        expq[2][$];
  logic [7:0]  mdl[2][DEPTH*4];
  int          settle[2];
  bit          hold[2], tie[2];
  logic [31:0] last_data[2];
  logic        last_err[2];
  int          retired[2];
  longint      acc_time[2];

  function automatic int lat(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d actual=%h required=%h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Reference: byte-addressed little-endian memory, whole-request semantics.
  function automatic void model_op(int d, logic w, logic [1:0] wid, logic uns,
                                   logic [31:0] a, logic [31:0] wd,
                                   output logic [31:0] data, output logic err);
    int     n;
    longint v;
    n    = (wid == 2'd0) ? 1 : (wid == 2'd1) ? 2 : 4;
    data = 32'd0;
    err  = (wid == 2'd3) || ((a % n) != 0) || (longint'(a) >= longint'(DEPTH * 4));
    if (!err) begin
      if (w) begin
        for (int i = 0; i < n; i++) mdl[d][a + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(mdl[d][a + i]) << (8 * i);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        data = v[31:0];
      end
    end
  endfunction

  // Compare process: every falling edge, check both DUTs against the model.
  always @(negedge clk) begin
    logic [31:0] ed;
    logic        ee;
    bit          busy, ev;
    exp_t        e;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        chk("rst_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
        chk("rst_req_ready", d, 32'(req_ready[d]), 32'd1);
        chk("rst_rsp_rdata", d, rsp_rdata[d], 32'd0);
        chk("rst_rsp_err", d, 32'(rsp_err[d]), 32'd0);
        expq[d].delete();
        settle[d] = 0;
      end else begin
        if (settle[d] < 4) settle[d]++;
        busy = (expq[d].size() != 0);
        if (settle[d] >= 4) chk("req_ready", d, 32'(req_ready[d]), 32'(!busy));
        ev = busy && ((cyc - expq[d][0].acc) >= longint'(lat(d)));
        chk("rsp_valid", d, 32'(rsp_valid[d]), 32'(ev));
        if (ev) begin
          e = expq[d][0];
          chk("rsp_rdata", d, rsp_rdata[d], e.data);
          chk("rsp_err", d, 32'(rsp_err[d]), 32'(e.err));
          if (rsp_ready[d]) begin
            last_data[d] = rsp_rdata[d];
            last_err[d]  = rsp_err[d];
            retired[d]++;
            void'(expq[d].pop_front());
          end
        end
        if (req_valid[d] && req_ready[d]) begin
          model_op(d, req_write[d], req_width[d], req_unsigned[d], req_addr[d], req_wdata[d], ed, ee);
          e.data = ed;
          e.err  = ee;
          e.acc  = cyc;
          expq[d].push_back(e);
        end
      end
    end
  end

  // Response back-pressure: held low, tied high or random per DUT.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++)
      rsp_ready[d] = hold[d] ? 1'b0 : (tie[d] ? 1'b1 : 1'($urandom_range(0, 1)));
  end

  task automatic present(int d, logic w, logic [1:0] wid, logic uns, logic [31:0] a, logic [31:0] wd);
    int n = 0;
    req_write[d] = w; req_width[d] = wid; req_unsigned[d] = uns;
    req_addr[d] = a; req_wdata[d] = wd; req_valid[d] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[d] && n < 100);
    if (!req_ready[d]) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout dut%0d actual=no_accept required=accept", d);
    end
    @(posedge clk);
    #1;
    acc_time[d] = $time;
  endtask

  // Drop valid and scramble the request fields, which must be ignored while busy.
  task automatic idle(int d);
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom);
    req_width[d] = 2'($urandom);
    req_unsigned[d] = 1'($urandom);
    req_addr[d] = $urandom;
    req_wdata[d] = $urandom;
  endtask

  task automatic drain(int d);
    int n = 0;
    while (expq[d].size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (expq[d].size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout dut%0d actual=%0d required=0 pending", d, expq[d].size());
    end
  endtask

  task automatic op(int d, logic w, logic [1:0] wid, logic uns, logic [31:0] a, logic [31:0] wd);
    present(d, w, wid, uns, a, wd);
    idle(d);
    drain(d);
  endtask

  task automatic check_last(string name, int d, logic [31:0] data, logic err);
    chk({name, "_data"}, d, last_data[d], data);
    chk({name, "_err"}, d, 32'(last_err[d]), 32'(err));
  endtask

  task automatic do_reset(int d);
    rst_n[d] = 1'b0;
    #1;
    chk("async_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
    chk("async_req_ready", d, 32'(req_ready[d]), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n[d] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    int          r0;
    int          d;
    logic        w;
    logic [1:0]  wid;
    logic [31:0] a;
    longint      prev;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b1; req_valid[i] = 1'b0; req_write[i] = 1'b0; req_width[i] = 2'd0;
      req_unsigned[i] = 1'b0; req_addr[i] = 32'd0; req_wdata[i] = 32'd0; rsp_ready[i] = 1'b0;
      hold[i] = 1'b0; tie[i] = 1'b1; settle[i] = 0; retired[i] = 0;
      last_data[i] = 32'd0; last_err[i] = 1'b0; acc_time[i] = 0;
    end
    #1;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Fill both memories back to back with rsp_ready tied high, checking accept spacing.
    for (int k = 0; k < 2; k++) begin
      prev = 0;
      for (int wd = 0; wd < DEPTH; wd++) begin
        present(k, 1'b1, 2'd2, 1'b0, 32'(wd * 4), $urandom);
        if (wd > 0) chk("b2b_spacing", k, 32'(acc_time[k] - prev), 32'((lat(k) + 1) * 10));
        prev = acc_time[k];
      end
      idle(k);
      drain(k);
    end

    // Known cases on the LATENCY=1 instance.
    op(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    check_last("store_rsp", 0, 32'd0, 1'b0);
    op(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    check_last("load_word", 0, 32'hDEADBEEF, 1'b0);
    op(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
    op(0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h00000080);
    op(0, 1'b0, 2'd0, 1'b0, 32'h21, 32'd0);
    check_last("byte_signed", 0, 32'hFFFFFF80, 1'b0);
    op(0, 1'b0, 2'd0, 1'b1, 32'h21, 32'd0);
    check_last("byte_unsigned", 0, 32'h00000080, 1'b0);
    op(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    check_last("word_after_byte", 0, 32'h11228044, 1'b0);
    op(0, 1'b0, 2'd1, 1'b0, 32'h22, 32'd0);
    check_last("half_signed", 0, 32'h00001122, 1'b0);
    op(0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h0BADF00D);
    op(0, 1'b0, 2'd1, 1'b0, 32'h3, 32'd0);
    check_last("half_misaligned", 0, 32'd0, 1'b1);
    op(0, 1'b0, 2'd2, 1'b0, 32'h12, 32'd0);
    check_last("word_misaligned", 0, 32'd0, 1'b1);
    op(0, 1'b1, 2'd2, 1'b0, 32'(DEPTH * 4), 32'hCAFEF00D);
    check_last("store_out_of_range", 0, 32'd0, 1'b1);
    op(0, 1'b0, 2'd3, 1'b0, 32'h4, 32'd0);
    check_last("illegal_width", 0, 32'd0, 1'b1);
    op(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'd0);
    check_last("word0_unchanged", 0, 32'h0BADF00D, 1'b0);

    // LATENCY=3 with rsp_ready held low: response must wait, hold steady and retire once.
    op(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h600DCAFE);
    hold[1] = 1'b1;
    rsp_ready[1] = 1'b0;
    r0 = retired[1];
    present(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
    idle(1);
    repeat (8) @(posedge clk);
    #1;
    chk("held_valid", 1, 32'(rsp_valid[1]), 32'd1);
    chk("no_retire_while_held", 1, 32'(retired[1]), 32'(r0));
    hold[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    drain(1);
    chk("single_retire", 1, 32'(retired[1] - r0), 32'd1);
    check_last("held_load", 1, 32'h600DCAFE, 1'b0);

    // Reset in WAIT: the accepted store persists, and the pending response disappears.
    r0 = retired[1];
    present(1, 1'b1, 2'd2, 1'b0, 32'h44, 32'h5A5A1234);
    idle(1);
    @(posedge clk);
    #1;
    do_reset(1);
    present(1, 1'b0, 2'd2, 1'b0, 32'h44, 32'd0);
    idle(1);
    do_reset(1);
    chk("no_rsp_after_reset", 1, 32'(retired[1]), 32'(r0));
    op(1, 1'b0, 2'd2, 1'b0, 32'h44, 32'd0);
    check_last("store_survives_reset", 1, 32'h5A5A1234, 1'b0);

    // Random traffic with random back-pressure on both instances.
    tie[0] = 1'b0;
    tie[1] = 1'b0;
    repeat (200) begin
      d   = int'($urandom_range(0, 1));
      w   = 1'($urandom);
      wid = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a   = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 + 15));
      if (wid != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << wid) - 32'd1);
      present(d, w, wid, 1'($urandom), a, $urandom);
      idle(d);
      if ($urandom_range(0, 1) == 1) drain(d);
    end
    tie[0] = 1'b1;
    tie[1] = 1'b1;
    drain(0);
    drain(1);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words of storage (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 1, cycles from request accept to response valid (legal 1..4).
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_width  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 req_addr  input  32  byte address.
REQ-012 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  initiator accepts response.
REQ-015 rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-016 rsp_err  output  1  request faulted (misaligned, out of range or illegal width).

Function
REQ-017 SHALL use a three-state FSM: IDLE, WAIT, RESP.
REQ-018 IDLE: req_ready=1; req_valid=1 accepts the request, latches all req_* fields and loads a latency counter with LATENCY-1.
REQ-019 On accept, the FSM goes to RESP if LATENCY=1, otherwise to WAIT.
REQ-020 WAIT: req_ready=0; the counter decrements each cycle and the FSM goes to RESP when it reaches 0.
REQ-021 RESP: rsp_valid=1 and rsp_rdata/rsp_err are held stable until rsp_ready=1; req_ready=0.
REQ-022 RESP with rsp_ready=1: the response retires and the FSM returns to IDLE; no new request is accepted in that same cycle, so one request is outstanding at most.
REQ-023 Each load or store SHALL produce exactly one response.
REQ-024 Misaligned access (half with addr[0]=1; word with addr[1:0]!=0) SHALL set rsp_err=1 and rsp_rdata=0, with no memory write.
REQ-025 Out-of-range access (addr[31:2] >= DEPTH_WORDS) SHALL set rsp_err=1 and rsp_rdata=0, with no memory write; addresses never wrap.
REQ-026 req_width=11 SHALL set rsp_err=1 and rsp_rdata=0, with no memory write.
REQ-027 Legal store SHALL write the byte enables selected by addr[1:0] and width exactly once, at the accept edge.
REQ-028 The store response SHALL carry rsp_rdata=0 and rsp_err=0.
REQ-029 Legal load SHALL read the word at the accept edge.
REQ-030 Loaded data SHALL be shifted by addr[1:0]×8, masked to width and extended per req_unsigned.
REQ-031 A load SHALL observe all stores responded to earlier (read-after-write ordering).
REQ-032 req_* inputs SHALL be ignored outside the IDLE accept cycle; changes while busy have no effect.
REQ-033 Storage SHALL be a synchronous array of DEPTH_WORDS×32 with per-byte write enables.

Reset
REQ-034 rst_n=0 SHALL immediately force state IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-035 Reset mid-transaction SHALL drop the pending response; a store already accepted stays written.
REQ-036 Memory contents SHALL NOT be reset.
REQ-037 Reset release SHALL be synchronised internally; the first request is accepted no earlier than the second rising edge after release.

Verification
REQ-038 Store word 0xDEADBEEF at 0x10, then load word from 0x10 (LATENCY=1) -> rsp_valid one cycle after accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-039 Store byte 0x80 at 0x21, then load byte signed -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word 0x20 -> bits [15:8]=0x80 and other bytes unchanged.
REQ-040 Load half at 0x03 -> rsp_err=1, rsp_rdata=0; load word at 0x12 -> rsp_err=1; store to DEPTH_WORDS×4 -> rsp_err=1, and memory word 0 is unchanged.
REQ-041 LATENCY=3, rsp_ready held 0 for 5 cycles -> rsp_valid rises 3 cycles after accept, rsp_rdata stays stable, req_ready=0 throughout, and a single retire occurs when rsp_ready=1.
REQ-042 Assert rst_n=0 while in WAIT -> rsp_valid=0 and req_ready=1 immediately, with no response after release.
REQ-043 Back-to-back requests with rsp_ready tied 1 -> one accept every LATENCY+1 cycles, and responses arrive in order.
